cell_pos_reader: RTL and testbench

//  Read-side engine for one cell position memory (single-port RAM, 2-cycle read latency).
//  On start: reads word 0 (particle count), then streams particles at addresses 1..N
//  as {posz,posy,posx} on a valid/ready output.

---
 rtl/cell_pos_reader_pkg.sv | 20 ++
 rtl/cell_pos_fifo.sv | 69 ++++++
 rtl/cell_pos_reader.sv | 208 ++++++++++++++++++++
 tb/tb_cell_pos_reader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cell_pos_reader_pkg.sv
// Shared constants for the cell position reader: field widths, default
// geometry and the FSM state encodings.
package cell_pos_reader_pkg;

  localparam int unsigned POS_WIDTH       = 32;
  localparam int unsigned CR_DATA_WIDTH   = 3 * POS_WIDTH;
  localparam int unsigned CR_PARTICLE_NUM = 220;
  localparam int unsigned CR_ADDR_WIDTH   = 8;
  localparam int unsigned CR_FIFO_DEPTH   = 4;

  localparam int unsigned CR_STATE_W = 3;

  localparam logic [2:0] CR_IDLE     = 3'd0;
  localparam logic [2:0] CR_RD_CNT   = 3'd1;
  localparam logic [2:0] CR_WAIT_CNT = 3'd2;
  localparam logic [2:0] CR_STREAM   = 3'd3;
  localparam logic [2:0] CR_DRAIN    = 3'd4;
  localparam logic [2:0] CR_DONE     = 3'd5;

endpackage

// File: rtl/cell_pos_fifo.sv
// Shift-style synchronous FIFO: the head entry always lives in slot 0, so the
// read data comes straight from a flop and stays put while not popped.
module cell_pos_fifo #(
  parameter int unsigned WIDTH = 105,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = $clog2(DEPTH);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;
  logic [IW-1:0]    wr_idx;

  // A pop frees its slot in the same cycle, so push-while-full is legal with pop.
  always_comb begin
    pop_ok  = pop && !empty_q;
    push_ok = push && (!full_q || pop_ok);
    entry_d = entry_q;
    if (pop_ok) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        entry_d[i] = entry_q[i+1];
      end
    end
    wr_idx = pop_ok ? IW'(count_q - CW'(1)) : IW'(count_q);
    if (push_ok) begin
      entry_d[wr_idx] = wdata;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign rdata = entry_q[0];
  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/cell_pos_reader.sv
// Read engine for one cell position RAM: fetches the particle count from word 0,
// then streams words 1..N through a credit-limited output FIFO.
module cell_pos_reader
  import cell_pos_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = CR_DATA_WIDTH,
  parameter int unsigned PARTICLE_NUM = CR_PARTICLE_NUM,
  parameter int unsigned ADDR_WIDTH   = CR_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH   = CR_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  cnt_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  pos_valid,
  input  logic                  pos_ready,
  output logic [DATA_WIDTH-1:0] pos_data,
  output logic [ADDR_WIDTH-1:0] pos_id,
  output logic                  pos_last
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);

  logic [CR_STATE_W-1:0] state_q, state_d;
  logic                  wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] next_id_q, next_id_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic                  mem_rden_q, mem_rden_d;
  logic                  stream_rd_q, stream_rd_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic                  cnt_err_q, cnt_err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  vld1_q, vld1_d, vld2_q, vld2_d;
  logic [ADDR_WIDTH-1:0] id1_q, id1_d, id2_q, id2_d;

  logic [ADDR_WIDTH-1:0] n_raw, n_lat;
  logic                  n_over;
  logic [SW-1:0]         credit_sum;
  logic                  credit_ok;
  logic                  drain_empty;

  logic                  fifo_push, fifo_pop;
  logic [EW-1:0]         fifo_wdata, fifo_rdata;
  logic                  fifo_empty, fifo_full;
  logic [CW-1:0]         fifo_count;

  assign fifo_pop   = pos_valid & pos_ready;
  assign fifo_push  = vld2_q;
  assign fifo_wdata = {(id2_q == n_q), id2_q, mem_q};

  // Credit counts words issued but not yet accepted; a pop this cycle frees one.
  always_comb begin
    n_raw       = mem_q[ADDR_WIDTH-1:0];
    n_over      = (n_raw > MAX_N);
    n_lat       = n_over ? MAX_N : n_raw;
    credit_sum  = SW'(fifo_count) + SW'(inflight_q) - SW'(fifo_pop);
    credit_ok   = (credit_sum < SW'(FIFO_DEPTH)) && !(fifo_full && !fifo_pop);
    drain_empty = fifo_empty || ((fifo_count == CW'(1)) && fifo_pop);
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    n_d           = n_q;
    next_id_d     = next_id_q;
    mem_address_d = mem_address_q;
    mem_rden_d    = 1'b0;
    stream_rd_d   = 1'b0;
    cnt_err_d     = cnt_err_q;
    case (state_q)
      CR_IDLE: begin
        if (start) begin
          state_d       = CR_RD_CNT;
          mem_rden_d    = 1'b1;
          mem_address_d = '0;
          cnt_err_d     = 1'b0;
        end
      end
      CR_RD_CNT: begin
        state_d = CR_WAIT_CNT;
        wait_d  = 1'b0;
      end
      CR_WAIT_CNT: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          n_d       = n_lat;
          cnt_err_d = n_over;
          if (n_lat == '0) begin
            state_d = CR_DONE;
          end else begin
            // Count word is visible now, so the first particle read goes out directly.
            state_d       = (n_lat == ADDR_WIDTH'(1)) ? CR_DRAIN : CR_STREAM;
            mem_rden_d    = 1'b1;
            stream_rd_d   = 1'b1;
            mem_address_d = ADDR_WIDTH'(1);
            next_id_d     = ADDR_WIDTH'(2);
          end
        end
      end
      CR_STREAM: begin
        if (credit_ok) begin
          mem_rden_d    = 1'b1;
          stream_rd_d   = 1'b1;
          mem_address_d = next_id_q;
          next_id_d     = next_id_q + ADDR_WIDTH'(1);
          if (next_id_q == n_q) begin
            state_d = CR_DRAIN;
          end
        end
      end
      CR_DRAIN: begin
        if ((inflight_q == '0) && drain_empty) begin
          state_d = CR_DONE;
        end
      end
      CR_DONE: begin
        state_d = CR_IDLE;
      end
      default: begin
        state_d = CR_IDLE;
      end
    endcase
    busy_d = (state_d != CR_IDLE);
    done_d = (state_d == CR_DONE);
  end

  // Valid/id shift register tracks the RAM's two-cycle read latency.
  always_comb begin
    vld1_d     = stream_rd_q;
    id1_d      = mem_address_q;
    vld2_d     = vld1_q;
    id2_d      = id1_q;
    inflight_d = inflight_q + CW'(stream_rd_d) - CW'(vld2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CR_IDLE;
      wait_q        <= 1'b0;
      n_q           <= '0;
      next_id_q     <= '0;
      mem_address_q <= '0;
      mem_rden_q    <= 1'b0;
      stream_rd_q   <= 1'b0;
      inflight_q    <= '0;
      cnt_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      vld1_q        <= 1'b0;
      vld2_q        <= 1'b0;
      id1_q         <= '0;
      id2_q         <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      n_q           <= n_d;
      next_id_q     <= next_id_d;
      mem_address_q <= mem_address_d;
      mem_rden_q    <= mem_rden_d;
      stream_rd_q   <= stream_rd_d;
      inflight_q    <= inflight_d;
      cnt_err_q     <= cnt_err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      vld1_q        <= vld1_d;
      vld2_q        <= vld2_d;
      id1_q         <= id1_d;
      id2_q         <= id2_d;
    end
  end

  cell_pos_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign cnt_err     = cnt_err_q;
  assign mem_address = mem_address_q;
  assign mem_rden    = mem_rden_q;
  assign pos_valid   = ~fifo_empty;
  assign pos_data    = fifo_rdata[DATA_WIDTH-1:0];
  assign pos_id      = fifo_rdata[DATA_WIDTH +: ADDR_WIDTH];
  assign pos_last    = fifo_rdata[EW-1];

endmodule

// File: tb/tb_cell_pos_reader.sv
// Bench for cell_pos_reader: 2-cycle RAM model, table of cell reads with
// expected timing, scoreboard of RAM words 1..N, reset and busy-start sequences.
module tb_cell_pos_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int FD = 4;
  localparam int EW = DW + AW + 1;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, cnt_err;
  logic [AW-1:0] mem_address, pos_id;
  logic          mem_rden, pos_valid, pos_ready, pos_last;
  logic [DW-1:0] mem_q = '0;
  logic [DW-1:0] pos_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural RAM: address captured on one edge, data out on the next.
  logic [DW-1:0] ram [256];
  logic          ram_v1 = 1'b0;
  logic [AW-1:0] ram_a1 = '0;
  always @(posedge clk) begin
    ram_v1 <= mem_rden;
    ram_a1 <= mem_address;
    if (ram_v1) mem_q <= ram[ram_a1];
  end

  cell_pos_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .cnt_err     (cnt_err),
    .mem_address (mem_address),
    .mem_rden    (mem_rden),
    .mem_q       (mem_q),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .pos_data    (pos_data),
    .pos_id      (pos_id),
    .pos_last    (pos_last)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode 0: ready always; 1: ready low through cycle 20; 2: ready random 50%
  // exp_first/exp_done: -1 = never happens, -2 = not checked
  typedef struct {
    string         name;
    logic [DW-1:0] w0;
    int            mode;
    int            exp_n;
    bit            exp_err;
    int            exp_first;
    int            exp_done;
  } vec_t;

  task automatic run_read(input vec_t v, input int extra_k);
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e, cur, prev;
    bit hold;
    int issues, cnt_reads, outst, max_outst, first_k, done_k, ndone, issues_at_stall;
    issues = 0; cnt_reads = 0; outst = 0; max_outst = 0;
    first_k = -1; done_k = -1; ndone = 0; issues_at_stall = -1;
    hold = 1'b0; prev = '0;
    ram[0] = v.w0;
    for (int i = 1; i < 256; i++) ram[i] = {$urandom, $urandom, $urandom};
    for (int i = 1; i <= v.exp_n; i++) exp_q.push_back({(i == v.exp_n), AW'(i), ram[i]});
    @(negedge clk);
    start = 1'b1;
    pos_ready = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      start = (k == extra_k);
      case (v.mode)
        0:       pos_ready = 1'b1;
        1:       pos_ready = (k > 20);
        default: pos_ready = 1'($urandom_range(0, 1));
      endcase
      if (k == 1) begin
        chk({v.name, "/accept"}, {busy, mem_rden, cnt_err, done}, 4'b1100);
        chk({v.name, "/cnt_addr"}, mem_address, 0);
      end
      if (mem_rden) begin
        if (mem_address == '0) cnt_reads++;
        else begin issues++; outst++; end
      end
      if (outst > max_outst) max_outst = outst;
      if (k == 20) issues_at_stall = issues;
      cur = {pos_last, pos_id, pos_data};
      if (hold) chk({v.name, "/hold"}, {pos_valid, cur}, {1'b1, prev});
      if (pos_valid && first_k < 0) first_k = k;
      if (pos_valid && pos_ready) begin
        outst--;
        if (exp_q.size() == 0) chk({v.name, "/extra_word"}, cur, 0);
        else begin
          e = exp_q.pop_front();
          chk({v.name, "/word"}, cur, e);
        end
      end
      hold = pos_valid && !pos_ready;
      prev = cur;
      if (done) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k;
          chk({v.name, "/busy_at_done"}, busy, 1);
        end
      end
      if (done_k >= 0 && k == done_k + 1) chk({v.name, "/idle_after"}, {busy, done}, 0);
      if (done_k >= 0 && k == done_k + 3) break;
    end
    start = 1'b0;
    chk({v.name, "/done_seen"}, (done_k >= 0), 1);
    chk({v.name, "/done_pulses"}, ndone, 1);
    chk({v.name, "/undelivered"}, exp_q.size(), 0);
    chk({v.name, "/issues"}, issues, v.exp_n);
    chk({v.name, "/count_reads"}, cnt_reads, 1);
    chk({v.name, "/cnt_err"}, cnt_err, v.exp_err);
    chk({v.name, "/credit_max"}, (max_outst <= FD) ? 0 : max_outst, 0);
    if (v.exp_first != -2) chk({v.name, "/first_valid"}, first_k, v.exp_first);
    if (v.exp_done != -2)  chk({v.name, "/done_cycle"}, done_k, v.exp_done);
    if (v.mode == 1)       chk({v.name, "/issued_in_stall"}, issues_at_stall, FD);
  endtask

  vec_t vecs[9];
  vec_t rv;
  bit   found;

  initial begin
    // Cycle k counts negedges after the edge that samples start.
    vecs[0] = '{"n5",      {88'h0, 8'd5},   0, 5,   1'b0, 7,  12};
    vecs[1] = '{"n0",      {88'h0, 8'd0},   0, 0,   1'b0, -1, 4};
    vecs[2] = '{"stall8",  {88'h0, 8'd8},   1, 8,   1'b0, -2, -2};
    vecs[3] = '{"over250", {88'h1234_5678_9abc_def0_1122_33, 8'd250}, 0, 219, 1'b1, 7, 226};
    vecs[4] = '{"n1",      {88'h0, 8'd1},   0, 1,   1'b0, 7,  8};
    vecs[5] = '{"hibits3", {88'hFFFF_FFFF_FFFF_FFFF_FFFF_FF, 8'd3}, 0, 3, 1'b0, 7, 10};
    vecs[6] = '{"rnd219",  {88'h0, 8'd219}, 2, 219, 1'b0, -2, -2};
    vecs[7] = '{"eq220",   {88'h0, 8'd220}, 0, 219, 1'b1, 7,  226};
    vecs[8] = '{"max219",  {88'h0, 8'd219}, 0, 219, 1'b0, 7,  226};

    rst_n = 1'b0; start = 1'b0; pos_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, cnt_err, mem_rden, pos_valid, pos_last}, 0);
    chk("reset_addr", {mem_address, pos_id}, 0);
    chk("reset_data", pos_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_read(vecs[i], -1);

    for (int r = 0; r < 4; r++) begin
      rv.name = "rand_n";
      rv.exp_n = $urandom_range(0, 60);
      rv.w0 = {$urandom, $urandom, 24'($urandom), 8'(rv.exp_n)};
      rv.mode = 2;
      rv.exp_err = 1'b0;
      rv.exp_first = (rv.exp_n == 0) ? -1 : -2;
      rv.exp_done = -2;
      run_read(rv, -1);
    end

    // Reset while word 3 is presented, then a clean read with a start pulsed mid-read.
    ram[0] = {88'h0, 8'd10};
    for (int i = 1; i < 256; i++) ram[i] = {$urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b1; pos_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (pos_valid && pos_id == AW'(3)) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_reach_id3", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {busy, done, cnt_err, mem_rden, mem_address, pos_valid, pos_id, pos_last, pos_data}, 0);
    @(posedge clk);
    #1;
    chk("rst_edge", {busy, done, cnt_err, mem_rden, mem_address, pos_valid, pos_id, pos_last, pos_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{"after_rst", {88'h0, 8'd6}, 0, 6, 1'b0, 7, 13};
    run_read(rv, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
